wheel_pulse_conditioner: RTL and testbench

//   Front end of the taxi meter. Turns the raw, bouncy wheel-sensor input into the clean
//   one-cycle distance_pulse_10m strobe consumed by the taxi fare core.

---
 rtl/taxi_pkg.sv | 17 +
 rtl/wheel_pulse_conditioner_if.sv | 32 +++
 rtl/debounce_filter.sv | 95 +++++++++
 rtl/wheel_pulse_conditioner.sv | 103 ++++++++++
 tb/tb_wheel_pulse_conditioner.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_pkg.sv
// Shared types and defaults for the taxi-meter wheel front end.
package taxi_pkg;

   typedef enum logic [2:0] {
      PRIME,
      LOW,
      CONF_HI,
      HIGH,
      CONF_LO
   } db_state_e;

   localparam int CAL_W             = 16;
   localparam int DEF_TICKS_PER_10M = 16;
   localparam int DEF_DEBOUNCE_CYC  = 3;
   localparam int DEF_STALL_CNT     = 2000;

endpackage

// File: rtl/wheel_pulse_conditioner_if.sv
// Sensor-side and meter-side signals of the wheel pulse conditioner.
// WHEEL_CAL_EN adds the runtime calibration pair cal_ticks/cal_load.
interface wheel_pulse_conditioner_if #(
   parameter int DW = 32
);
   logic                       wheel_tick_raw;
   logic                       distance_pulse_10m;
   logic                       moving;
   logic [DW-1:0]              tick_total;
`ifdef WHEEL_CAL_EN
   logic [taxi_pkg::CAL_W-1:0] cal_ticks;
   logic                       cal_load;

   modport master (
      output wheel_tick_raw, cal_ticks, cal_load,
      input  distance_pulse_10m, moving, tick_total
   );
   modport slave (
      input  wheel_tick_raw, cal_ticks, cal_load,
      output distance_pulse_10m, moving, tick_total
   );
`else
   modport master (
      output wheel_tick_raw,
      input  distance_pulse_10m, moving, tick_total
   );
   modport slave (
      input  wheel_tick_raw,
      output distance_pulse_10m, moving, tick_total
   );
`endif
endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus debounce FSM; emits a registered one-cycle tick
// on each confirmed low-to-high transition of the wheel sensor.
module debounce_filter
   import taxi_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic tick_o
);

   localparam logic [7:0] CONF = 8'(DEBOUNCE_CYC);

   logic      sync1_q, sync2_q;
   db_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic      lvl_q, lvl_d;
   logic      tick_q, tick_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= PRIME;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         tick_q  <= tick_d;
      end
   end

   // A full confirm count wins over the current sample, so exactly DEBOUNCE_CYC
   // stable samples are enough to accept a level change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      tick_d  = 1'b0;
      case (state_q)
         PRIME: begin
            if (sync2_q != lvl_q) begin
               lvl_d = sync2_q;
               cnt_d = 8'd1;
            end else if (cnt_q >= CONF) begin
               state_d = lvl_q ? HIGH : LOW;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         LOW: begin
            if (sync2_q) begin
               state_d = CONF_HI;
               cnt_d   = 8'd1;
            end
         end
         CONF_HI: begin
            if (cnt_q >= CONF) begin
               state_d = HIGH;
               tick_d  = 1'b1;
            end else if (!sync2_q) begin
               state_d = LOW;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HIGH: begin
            if (!sync2_q) begin
               state_d = CONF_LO;
               cnt_d   = 8'd1;
            end
         end
         CONF_LO: begin
            if (cnt_q >= CONF) begin
               state_d = LOW;
            end else if (sync2_q) begin
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = PRIME;
      endcase
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/wheel_pulse_conditioner.sv
// Taxi-meter wheel front end: debounce, ticks-per-10m divider, tick odometer
// and stall watchdog. Define WHEEL_CAL_EN for a runtime-loadable divisor.
module wheel_pulse_conditioner
   import taxi_pkg::*;
#(
   parameter int DW            = 32,
   parameter int TICKS_PER_10M = DEF_TICKS_PER_10M,
   parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
   parameter int STALL_CNT     = DEF_STALL_CNT
) (
   input  logic                      clk,
   input  logic                      rst,
   wheel_pulse_conditioner_if.slave  bus
);

   localparam int               SW        = $clog2(STALL_CNT + 1);
   localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_CNT);
   localparam logic [CAL_W-1:0] N_RST     = CAL_W'(TICKS_PER_10M);

   logic             tick;
   logic [CAL_W-1:0] n_cur;
   logic             cal_ok;
   logic [CAL_W-1:0] div_q, div_d;
   logic             pulse_q, pulse_d;
   logic [DW-1:0]    total_q, total_d;
   logic [SW-1:0]    stall_q, stall_d;
   logic             moving_q, moving_d;

   debounce_filter #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (bus.wheel_tick_raw),
      .tick_o (tick)
   );

`ifdef WHEEL_CAL_EN
   logic [CAL_W-1:0] n_q, n_d;

   // A zero divisor would never complete a group, so such loads are dropped.
   assign cal_ok = bus.cal_load && (bus.cal_ticks != '0);
   assign n_d    = cal_ok ? bus.cal_ticks : n_q;
   assign n_cur  = n_q;

   always_ff @(posedge clk) begin
      if (rst) n_q <= N_RST;
      else     n_q <= n_d;
   end
`else
   assign cal_ok = 1'b0;
   assign n_cur  = N_RST;
`endif

   always_comb begin
      div_d    = div_q;
      pulse_d  = 1'b0;
      total_d  = total_q + DW'(tick);
      stall_d  = stall_q;
      moving_d = moving_q;

      if (cal_ok) begin
         div_d = '0;
      end else if (tick) begin
         if (div_q >= n_cur - 1'b1) begin
            div_d   = '0;
            pulse_d = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      // A tick arriving on the saturating cycle keeps the wheel marked as moving.
      if (tick) begin
         stall_d  = '0;
         moving_d = 1'b1;
      end else if (stall_q != STALL_MAX) begin
         stall_d = stall_q + 1'b1;
         if (stall_q + 1'b1 == STALL_MAX) moving_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         pulse_q  <= 1'b0;
         total_q  <= '0;
         stall_q  <= '0;
         moving_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         pulse_q  <= pulse_d;
         total_q  <= total_d;
         stall_q  <= stall_d;
         moving_q <= moving_d;
      end
   end

   assign bus.distance_pulse_10m = pulse_q;
   assign bus.moving             = moving_q;
   assign bus.tick_total         = total_q;

endmodule

// File: tb/tb_wheel_pulse_conditioner.sv
// Scoreboard bench for wheel_pulse_conditioner with a tick-level reference model.
module tb_wheel_pulse_conditioner;

   localparam int TPK   = 4;
   localparam int DB    = 3;
   localparam int STALL = 20;

   typedef struct {
      int          e;
      int unsigned tot;
   } exp_t;

   logic clk;
   logic rst;
   int   edge_n = 0;
   int   checks = 0;
   int   failures = 0;
   int   pulses_seen = 0;
   bit   chk_en = 1'b0;

   exp_t        exp_q[$];
   int          tick_edges[$];
   int          last_t = -1;
   int unsigned m_total = 0;
   int          m_div = 0;
   int          m_n = TPK;

   wheel_pulse_conditioner_if #(.DW(32)) bus ();

   wheel_pulse_conditioner #(
      .DW            (32),
      .TICKS_PER_10M (TPK),
      .DEBOUNCE_CYC  (DB),
      .STALL_CNT     (STALL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic void check(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d (edge %0d)", nm, act, exp, edge_n);
      end
   endfunction

   // Reference: a settled rise sampled at edge k shows up on the outputs at edge k+3+DB.
   function automatic void model_tick(int k);
      int t;
      t = k + 3 + DB;
      tick_edges.push_back(t);
      m_total++;
      m_div++;
      if (m_div >= m_n) begin
         m_div = 0;
         exp_q.push_back('{t, m_total});
      end
   endfunction

   always @(negedge clk) begin
      if (!chk_en) begin
         last_t = -1;
      end else begin
         exp_t x;
         while (tick_edges.size() > 0 && tick_edges[0] <= edge_n) last_t = tick_edges.pop_front();
         check("moving", bus.moving, (last_t >= 0 && (edge_n - last_t) < STALL) ? 1 : 0);
         if (bus.distance_pulse_10m) begin
            pulses_seen++;
            if (exp_q.size() == 0) begin
               check("pulse_unexpected", bus.distance_pulse_10m, 0);
            end else begin
               x = exp_q.pop_front();
               check("pulse_edge", edge_n, x.e);
               check("pulse_total", bus.tick_total, x.tot);
            end
         end else if (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
            check("pulse_missing", bus.distance_pulse_10m, 1);
            x = exp_q.pop_front();
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(logic lvl);
      chk_en = 1'b0;
      bus.wheel_tick_raw = lvl;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      exp_q.delete();
      tick_edges.delete();
      m_total = 0;
      m_div = 0;
      m_n = TPK;
      chk_en = 1'b1;
   endtask

   task automatic do_tick(int hi, int lo, int nbr, int nbf);
      for (int b = 0; b < nbr; b++) begin
         bus.wheel_tick_raw = 1'b1;
         step(int'($urandom_range(1, 2)));
         bus.wheel_tick_raw = 1'b0;
         step(int'($urandom_range(1, 2)));
      end
      bus.wheel_tick_raw = 1'b1;
      model_tick(edge_n + 1);
      step(hi);
      for (int b = 0; b < nbf; b++) begin
         bus.wheel_tick_raw = 1'b0;
         step(int'($urandom_range(1, 2)));
         bus.wheel_tick_raw = 1'b1;
         step(int'($urandom_range(1, 2)));
      end
      bus.wheel_tick_raw = 1'b0;
      step(lo);
   endtask

`ifdef WHEEL_CAL_EN
   task automatic load_cal(int v);
      bus.cal_ticks = 16'(v);
      bus.cal_load  = 1'b1;
      if (v != 0) begin
         m_n = v;
         m_div = 0;
      end
      step(1);
      bus.cal_load = 1'b0;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      rst = 1'b1;
      bus.wheel_tick_raw = 1'b0;
`ifdef WHEEL_CAL_EN
      bus.cal_ticks = '0;
      bus.cal_load  = 1'b0;
`endif
      step(2);
      do_reset(1'b0);
      check("rst_pulse", bus.distance_pulse_10m, 0);
      check("rst_moving", bus.moving, 0);
      check("rst_total", bus.tick_total, 0);
      step(10);

      // Clean ticks
      p0 = pulses_seen;
      repeat (8) do_tick(10, 10, 0, 0);
      check("clean_pulses", pulses_seen - p0, 2);
      check("clean_total", bus.tick_total, 8);

      // Bouncy edges, then an isolated short glitch
      do_reset(1'b0);
      step(10);
      p0 = pulses_seen;
      repeat (8) do_tick(10, 10, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      check("bounce_pulses", pulses_seen - p0, 2);
      check("bounce_total", bus.tick_total, 8);
      bus.wheel_tick_raw = 1'b1;
      step(2);
      bus.wheel_tick_raw = 1'b0;
      step(10);
      check("glitch_total", bus.tick_total, 8);

      // Sensor high through reset release
      do_reset(1'b1);
      step(10);
      check("prime_high_total", bus.tick_total, 0);
      bus.wheel_tick_raw = 1'b0;
      step(10);
      check("prime_low_total", bus.tick_total, 0);
      do_tick(10, 10, 0, 0);
      check("prime_first_total", bus.tick_total, 1);

      // Stall then resume
      step(25);
      check("stall_moving", bus.moving, 0);
      do_tick(10, 10, 0, 0);
      check("resume_moving", bus.moving, 1);

      // Reset discards a partial group
      do_reset(1'b0);
      step(10);
      repeat (3) do_tick(8, 8, 0, 0);
      step(5);
      do_reset(1'b0);
      step(10);
      p0 = pulses_seen;
      repeat (4) do_tick(8, 8, 0, 0);
      check("midrst_pulses", pulses_seen - p0, 1);
      check("midrst_total", bus.tick_total, 4);

      // Randomized traffic, including gaps long enough to stall
      repeat (24) do_tick(int'($urandom_range(6, 14)), int'($urandom_range(6, 30)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      check("random_total", bus.tick_total, m_total);

`ifdef WHEEL_CAL_EN
      do_reset(1'b0);
      step(10);
      do_tick(10, 10, 0, 0);
      load_cal(2);
      step(3);
      p0 = pulses_seen;
      repeat (4) do_tick(10, 10, 0, 0);
      check("cal2_pulses", pulses_seen - p0, 2);
      load_cal(0);
      step(3);
      p0 = pulses_seen;
      repeat (2) do_tick(10, 10, 0, 0);
      check("cal0_pulses", pulses_seen - p0, 1);
      check("cal_total", bus.tick_total, 7);
`endif

      step(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
